// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative 32-bit multiply/divide unit with HI/LO registers
//
// Computes MULT/MULTU/DIV/DIVU one bit per cycle and writes HI/LO in a final
// fix-up cycle. Optional divider: define MULDIV_DIV_EN to build DIV/DIVU;
// without it, divide requests pulse illegal_o and leave HI/LO untouched.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   start_i, op_i      request and op (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   rs_data_i          operand A (multiplicand / dividend)
//   rt_data_i          operand B (multiplier / divisor)
//   CacheStall_i       freezes all internal state while high
//   busy_o             operation in flight, doubles as pipeline stall request
//   done_o             one-cycle pulse when HI/LO are written
//   div_zero_o         pulses with done_o for a zero divisor
//   illegal_o          one-cycle pulse for a divide when the divider is absent
//   hi_o, lo_o         architectural HI/LO registers
module ex_muldiv #(
    parameter int XLEN = 32,
    parameter int CW   = $clog2(XLEN) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs_data_i,
    input  logic [XLEN-1:0] rt_data_i,
    input  logic            CacheStall_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            div_zero_o,
    output logic            illegal_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [XLEN-1:0]     mag_a_q;
    logic                sign_a_q, sign_b_q;
    logic                busy_q, done_q, dz_out_q;
    logic [XLEN-1:0]     hi_q, lo_q;

    logic                accept;
    logic                in_sign_a, in_sign_b;
    logic [XLEN-1:0]     in_mag_a, in_mag_b;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_step, prod_fix;
    logic [XLEN-1:0]     fix_hi, fix_lo;

`ifdef MULDIV_DIV_EN
    logic                op_div_q, dz_q;
    logic [XLEN-1:0]     mag_b_q;
    logic                div_zero_req;
    logic [XLEN:0]       rem_shift, rem_diff;
    logic [2*XLEN-1:0]   div_step;
`else
    logic                illegal_q;
`endif

    // Operand conditioning: signed ops work on magnitudes, signs kept aside.
    always_comb begin
        accept    = (state_q == S_IDLE) && start_i && !CacheStall_i;
        in_sign_a = !op_i[0] && rs_data_i[XLEN-1];
        in_sign_b = !op_i[0] && rt_data_i[XLEN-1];
        in_mag_a  = in_sign_a ? -rs_data_i : rs_data_i;
        in_mag_b  = in_sign_b ? -rt_data_i : rt_data_i;
    end

    // Shift-add: acc holds {partial product, remaining multiplier bits}.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                   (acc_q[0] ? {1'b0, mag_a_q} : {(XLEN+1){1'b0}});
        mul_step = {mul_sum, acc_q[XLEN-1:1]};
        prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    end

`ifdef MULDIV_DIV_EN
    // Restoring divide: acc holds {remainder, dividend/quotient}. The
    // shifted remainder is below 2*divisor, so bit XLEN of the difference
    // is a clean borrow flag.
    always_comb begin
        div_zero_req = op_i[1] && (rt_data_i == '0);
        rem_shift    = acc_q[2*XLEN-1:XLEN-1];
        rem_diff     = rem_shift - {1'b0, mag_b_q};
        div_step     = rem_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                      : {rem_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end

    always_comb begin
        fix_hi = prod_fix[2*XLEN-1:XLEN];
        fix_lo = prod_fix[XLEN-1:0];
        if (dz_q) begin
            fix_hi = sign_a_q ? -mag_a_q : mag_a_q;
            fix_lo = '1;
        end else if (op_div_q) begin
            fix_lo = (sign_a_q ^ sign_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
            fix_hi = sign_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        end
    end
`else
    always_comb begin
        fix_hi = prod_fix[2*XLEN-1:XLEN];
        fix_lo = prod_fix[XLEN-1:0];
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
`ifdef MULDIV_DIV_EN
                    state_d = div_zero_req ? S_FIX : S_CALC;
`else
                    state_d = op_i[1] ? S_IDLE : S_CALC;
`endif
                end
            end
            S_CALC: if (!CacheStall_i && cnt_q == CW'(1)) state_d = S_FIX;
            S_FIX:  if (!CacheStall_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            mag_a_q  <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_out_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef MULDIV_DIV_EN
            op_div_q <= 1'b0;
            dz_q     <= 1'b0;
            mag_b_q  <= '0;
`else
            illegal_q <= 1'b0;
`endif
        end else begin
            // Pulses last one cycle and are never held across a stall.
            done_q   <= 1'b0;
            dz_out_q <= 1'b0;
`ifndef MULDIV_DIV_EN
            illegal_q <= 1'b0;
`endif
            if (!CacheStall_i) begin
                case (state_q)
                    S_IDLE: begin
                        if (accept) begin
`ifdef MULDIV_DIV_EN
                            sign_a_q <= in_sign_a;
                            sign_b_q <= in_sign_b;
                            mag_a_q  <= in_mag_a;
                            mag_b_q  <= in_mag_b;
                            op_div_q <= op_i[1];
                            dz_q     <= div_zero_req;
                            cnt_q    <= CW'(XLEN);
                            busy_q   <= 1'b1;
                            acc_q    <= op_i[1] ? {{XLEN{1'b0}}, in_mag_a}
                                                : {{XLEN{1'b0}}, in_mag_b};
`else
                            if (op_i[1]) begin
                                illegal_q <= 1'b1;
                            end else begin
                                sign_a_q <= in_sign_a;
                                sign_b_q <= in_sign_b;
                                mag_a_q  <= in_mag_a;
                                cnt_q    <= CW'(XLEN);
                                busy_q   <= 1'b1;
                                acc_q    <= {{XLEN{1'b0}}, in_mag_b};
                            end
`endif
                        end
                    end
                    S_CALC: begin
                        cnt_q <= cnt_q - CW'(1);
`ifdef MULDIV_DIV_EN
                        acc_q <= op_div_q ? div_step : mul_step;
`else
                        acc_q <= mul_step;
`endif
                    end
                    S_FIX: begin
                        hi_q   <= fix_hi;
                        lo_q   <= fix_lo;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
`ifdef MULDIV_DIV_EN
                        dz_out_q <= dz_q;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign div_zero_o = dz_out_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
`ifdef MULDIV_DIV_EN
    assign illegal_o  = 1'b0;
`else
    assign illegal_o  = illegal_q;
`endif

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - self-checking bench for ex_muldiv
module tb_ex_muldiv;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] rs_data_i = '0;
    logic [31:0] rt_data_i = '0;
    logic        CacheStall_i = 1'b0;
    logic        busy_o, done_o, div_zero_o, illegal_o;
    logic [31:0] hi_o, lo_o;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic        dz;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t sb_q[$];

    ex_muldiv dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .CacheStall_i(CacheStall_i),
        .busy_o(busy_o), .done_o(done_o), .div_zero_o(div_zero_o),
        .illegal_o(illegal_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint pa, pb, ps;
        int     q, r;
        logic [63:0] p;
        e = '0;
        case (op)
            2'b00: begin
                pa = longint'($signed(a));
                pb = longint'($signed(b));
                ps = pa * pb;
                p  = ps;
                e.hi = p[63:32]; e.lo = p[31:0];
            end
            2'b01: begin
                p = {32'b0, a} * {32'b0, b};
                e.hi = p[63:32]; e.lo = p[31:0];
            end
            default: begin
                if (b == 0) begin
                    e.dz = 1'b1; e.hi = a; e.lo = 32'hFFFF_FFFF;
                end else if (op == 2'b11) begin
                    e.lo = a / b; e.hi = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000; e.hi = 32'h0;
                end else begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                    e.lo = q; e.hi = r;
                end
            end
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a posedge; the next posedge is the accept edge E0.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
        op_i = op; rs_data_i = a; rt_data_i = b; start_i = 1'b1;
        if (push) sb_q.push_back(model(op, a, b));
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    // Counts cycles from E0 until done_o, optionally stalling, then scores.
    task automatic run(input string tag, input int exp_cyc, input int stall_at, input int stall_len);
        int          cyc;
        bit          busy_bad, hold_bad;
        logic [31:0] h0, l0;
        exp_t        e;
        cyc = 0; busy_bad = 0; hold_bad = 0;
        h0 = hi_o; l0 = lo_o;
        while (!done_o && cyc < 200) begin
            if (cyc == stall_at) CacheStall_i = 1'b1;
            if (cyc == stall_at + stall_len) CacheStall_i = 1'b0;
            if (busy_o !== 1'b1) busy_bad = 1;
            if (hi_o !== h0 || lo_o !== l0) hold_bad = 1;
            @(posedge clk_i); #1;
            cyc++;
        end
        CacheStall_i = 1'b0;
        chk({tag, "_latency"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, "_busy_during"}, 64'(busy_bad), 64'd0);
        chk({tag, "_hilo_hold"}, 64'(hold_bad), 64'd0);
        chk({tag, "_busy_at_done"}, 64'(busy_o), 64'd0);
        if (sb_q.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_hi"}, 64'(hi_o), 64'(e.hi));
            chk({tag, "_lo"}, 64'(lo_o), 64'(e.lo));
            chk({tag, "_div_zero"}, 64'(div_zero_o), 64'(e.dz));
        end
    endtask

    initial begin
        bit done_seen;

        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_dz", 64'(div_zero_o), 64'd0);
        chk("rst_illegal", 64'(illegal_o), 64'd0);
        chk("rst_hi", 64'(hi_o), 64'd0);
        chk("rst_lo", 64'(lo_o), 64'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        run("multu_max", 33, -1, 0);
        chk("multu_max_hi_const", 64'(hi_o), 64'hFFFF_FFFE);
        chk("multu_max_lo_const", 64'(lo_o), 64'h0000_0001);

        issue(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b1);
        run("mult_neg3x5", 33, -1, 0);
        chk("mult_neg3x5_lo_const", 64'(lo_o), 64'hFFFF_FFF1);

        issue(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b1);
        run("mult_minmin", 33, -1, 0);
        issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        run("multu_mix", 33, -1, 0);
        issue(2'b00, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        run("mult_stall", 38, 10, 5);

`ifdef MULDIV_DIV_EN
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
        run("div_neg7_2", 33, -1, 0);
        chk("div_neg7_2_lo_const", 64'(lo_o), 64'hFFFF_FFFD);
        chk("div_neg7_2_hi_const", 64'(hi_o), 64'hFFFF_FFFF);
        issue(2'b11, 32'h0000_1234, 32'd0, 1'b1);
        run("divu_zero", 1, -1, 0);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run("div_ovf_stall", 38, 10, 5);
        issue(2'b11, 32'hDEAD_BEEF, 32'h0000_1235, 1'b1);
        run("divu_mix", 33, -1, 0);
        issue(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b1);
        run("div_7_neg2", 33, -1, 0);
        issue(2'b10, 32'hFFFF_FFF0, 32'd0, 1'b1);
        run("div_negzero", 1, -1, 0);
`endif

        issue(2'b01, 32'h0000_FFFF, 32'h0001_0001, 1'b0);
        repeat (9) begin @(posedge clk_i); #1; end
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_hi", 64'(hi_o), 64'd0);
        chk("midrst_lo", 64'(lo_o), 64'd0);
        chk("midrst_done", 64'(done_o), 64'd0);
        done_seen = 0;
        repeat (40) begin
            @(posedge clk_i); #1;
            if (done_o !== 1'b0 || busy_o !== 1'b0) done_seen = 1;
        end
        chk("midrst_quiet", 64'(done_seen), 64'd0);

        issue(2'b01, 32'd7, 32'd6, 1'b1);
        run("multu_7x6", 33, -1, 0);
        chk("multu_7x6_lo_const", 64'(lo_o), 64'd42);

`ifndef MULDIV_DIV_EN
        issue(2'b10, 32'h0000_0010, 32'd2, 1'b0);
        chk("ill_pulse", 64'(illegal_o), 64'd1);
        chk("ill_busy", 64'(busy_o), 64'd0);
        @(posedge clk_i); #1;
        chk("ill_pulse_end", 64'(illegal_o), 64'd0);
        chk("ill_busy_after", 64'(busy_o), 64'd0);
        chk("ill_done", 64'(done_o), 64'd0);
        chk("ill_hi", 64'(hi_o), 64'd0);
        chk("ill_lo", 64'(lo_o), 64'd42);
        issue(2'b11, 32'd9, 32'd0, 1'b0);
        chk("ill_divu_pulse", 64'(illegal_o), 64'd1);
        chk("ill_divu_dz", 64'(div_zero_o), 64'd0);
        @(posedge clk_i); #1;
        issue(2'b01, 32'd3, 32'd4, 1'b1);
        run("multu_3x4", 33, -1, 0);
        chk("multu_3x4_lo_const", 64'(lo_o), 64'd12);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative 32-bit multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the register operands and a decoded mul/div operation, and computes MULT/MULTU/DIV/DIVU over multiple cycles. Results land in architectural HI/LO registers, and the unit raises a stall toward the front of the pipeline while busy. It honours the global cache stall so that the pipeline freezes coherently.

## Interface

- XLEN, 32, operand width; counter width is clog2(XLEN)+1.
- clk_i  input  1  pipeline clock; all state changes on posedge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  request a new operation; sampled only in IDLE.
- op_i  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_i.
- rs_data_i  input  XLEN  operand A (multiplicand or dividend), from the ID/EX Reg_data1 output.
- rt_data_i  input  XLEN  operand B (multiplier or divisor), from the ID/EX Reg_data2 output.
- CacheStall_i  input  1  freezes all internal state while high.
- busy_o  output  1  operation in flight; also serves as the pipeline stall request.
- done_o  output  1  one-cycle pulse when HI/LO are updated.
- div_zero_o  output  1  pulses with done_o when the divisor was zero.
- illegal_o  output  1  one-cycle pulse for an unsupported op (see Configuration).
- hi_o  output  XLEN  HI register.
- lo_o  output  XLEN  LO register.

## Operation

- States: IDLE, CALC, FIX.
- IDLE, when start_i=1 and CacheStall_i=0:
  - Latch op_i, the sign flags, and the operand magnitudes. Signed ops take the two's-complement absolute value; unsigned ops take the raw value.
  - Load the counter with XLEN and go to CALC.
- Divide-by-zero: if the op is DIV or DIVU and rt_data_i=0 at accept, go straight to FIX and set the div-by-zero flag.
- CALC, one bit per cycle:
  - Multiply: shift-add on a 2*XLEN accumulator.
  - Divide: restoring shift-subtract, producing quotient and remainder.
  - The counter decrements each cycle. At counter=1, go to FIX on the next edge.
- FIX:
  - Multiply: negate the 64-bit product if sign(A)^sign(B) for MULT. {HI,LO} <= product.
  - Divide: LO <= quotient, negated if sign(A)^sign(B) (DIV only). HI <= remainder, negated if sign(A) (DIV only).
  - Divide-by-zero: LO <= all ones, HI <= rs magnitude restored to the original rs value.
  - Pulse done_o (and div_zero_o if applicable), then return to IDLE.
- Overflow case: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (falls out of the magnitude arithmetic).
- start_i while busy is ignored. The upstream stage must hold the instruction, which busy_o stalls.
- HI/LO change only in the FIX cycle and otherwise hold.
- Reset, including mid-operation:
  - The operation is aborted; state goes to IDLE and the counter to 0.
  - hi_o=0, lo_o=0, busy_o=0, done_o=0, div_zero_o=0, illegal_o=0.

## Timing

- Accept edge is E0, the first edge at which IDLE and start_i=1 and CacheStall_i=0.
- busy_o is high from E0 until the FIX edge completes.
- Normal op:
  - CALC occupies edges E0+1 through E0+XLEN.
  - FIX edge is E0+XLEN+1: HI/LO are updated, done_o is high for the following cycle, and busy_o is low.
  - Latency is XLEN+1 cycles (33 for XLEN=32).
- Divide-by-zero: FIX at E0+1, so latency is 1 cycle.
- CacheStall_i=1 on any edge:
  - No state, counter, or accumulator change, and done_o is not asserted.
  - Each stalled cycle adds one cycle of latency.
  - If FIX coincides with a stall, FIX is deferred.
- busy_o, done_o, div_zero_o, and illegal_o are registered outputs (no combinational paths from inputs).
- A new start_i is accepted in the cycle done_o is high, since the state is already IDLE.

## Configuration

- MULDIV_DIV_EN defined: all four ops are supported as described above.
- MULDIV_DIV_EN undefined:
  - The divider datapath is compiled out.
  - A DIV or DIVU start is accepted, leaves HI/LO unchanged, stays in IDLE, and pulses illegal_o for one cycle after E0.
  - busy_o, done_o, and div_zero_o never assert for DIV/DIVU. MULT and MULTU are unchanged.
- illegal_o is tied 0 when the macro is defined.

## Test plan

- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; done_o exactly 33 cycles after accept; busy_o high throughout.
- MULT 0xFFFFFFFD (-3) x 5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Then DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 0x00001234 / 0 -> done_o and div_zero_o one cycle after accept; LO=0xFFFFFFFF, HI=0x00001234.
- DIV 0x80000000 / 0xFFFFFFFF, with CacheStall_i high for 5 cycles during CALC -> LO=0x80000000, HI=0; done_o at 38 cycles; HI/LO frozen during the stall.
- Reset asserted at CALC cycle 10 -> next cycle busy_o=0, HI=LO=0, no done_o. A following MULTU 7x6 gives LO=42, HI=0.
- Build without MULDIV_DIV_EN: DIV start -> illegal_o pulse, busy_o stays 0, HI/LO unchanged; MULTU 3x4 still gives LO=12.
